// File: rtl/cga_line_doubler.sv
// cga_line_doubler: two-bank scan doubler replaying each CGA input line twice at dbl_ce rate.
// Ports: clk, reset (async, active-high); video/pix_ce capture pixels, line_reset starts a line;
// dbl_ce strobes output pixels; dbl_video/dbl_hsync form the doubled stream; line_len is the
// replayed line length; overflow is sticky once any line exceeds 2**ADDR_W pixels.
// Optional: define CGA_LINE_DOUBLER_SCANLINES_EN to add the scanlines input (darkens pass 1).
module cga_line_doubler #(
  parameter int ADDR_W        = 10,
  parameter int DBL_HSYNC_LEN = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        video,
  input  logic              pix_ce,
  input  logic              line_reset,
  input  logic              dbl_ce,
`ifdef CGA_LINE_DOUBLER_SCANLINES_EN
  input  logic              scanlines,
`endif
  output logic [3:0]        dbl_video,
  output logic              dbl_hsync,
  output logic [ADDR_W:0]   line_len,
  output logic              overflow
);
  localparam logic [7:0] SYNC = 8'(DBL_HSYNC_LEN);
  logic [3:0] mem [0:2**(ADDR_W+1)-1];
  logic [3:0] rdata;
  logic [ADDR_W:0] waddr, wa;
  logic [ADDR_W-1:0] raddr;
  logic [7:0] sync_cnt;
  logic wbank, pass, done, vld, full, we, rd, last, dark;
  // waddr saturates at exactly 2**ADDR_W, so its top bit marks a full bank
  assign full = waddr[ADDR_W];
  // a pixel coincident with line_reset already belongs to the new bank at address 0
  assign wa = line_reset ? {~wbank, {ADDR_W{1'b0}}} : {wbank, waddr[ADDR_W-1:0]};
  assign we = pix_ce && (line_reset || !full);
  assign rd = dbl_ce && !line_reset && !done && line_len != '0;
  assign last = {1'b0, raddr} == line_len - 1'b1;
`ifdef CGA_LINE_DOUBLER_SCANLINES_EN
  assign dark = scanlines && pass;
`else
  assign dark = 1'b0;
`endif
  assign dbl_hsync = sync_cnt != 8'd0;
  assign dbl_video = vld ? rdata : 4'h0;
  // kept free of reset so the buffer maps onto block RAM with a registered read port
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= video;
    if (rd) rdata <= mem[{~wbank, raddr}];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbank    <= 1'b0;
      waddr    <= '0;
      raddr    <= '0;
      pass     <= 1'b0;
      done     <= 1'b0;
      sync_cnt <= 8'd0;
      line_len <= '0;
      overflow <= 1'b0;
      vld      <= 1'b0;
    end else begin
      if (pix_ce && full && !line_reset) overflow <= 1'b1;
      if (line_reset) begin
        line_len <= waddr;
        wbank    <= ~wbank;
        waddr    <= {{ADDR_W{1'b0}}, pix_ce};
        raddr    <= '0;
        pass     <= 1'b0;
        done     <= 1'b0;
        sync_cnt <= SYNC;
      end else begin
        if (pix_ce && !full) waddr <= waddr + 1'b1;
        if (dbl_ce && dbl_hsync) sync_cnt <= sync_cnt - 1'b1;
        if (rd) begin
          raddr <= last ? '0 : raddr + 1'b1;
          if (last) begin
            pass <= 1'b1;
            done <= pass;
            if (!pass) sync_cnt <= SYNC;
          end
        end
      end
      // sync overlays pixels that are still consumed from the buffer
      if (dbl_ce) vld <= rd && !dbl_hsync && !dark;
    end
  end
endmodule

// File: doc/cga_line_doubler.md
Name: cga_line_doubler

Overview:
- Scan-doubler stage directly downstream of the CGA pixel pusher.
- Captures each input line of 4-bit IRGB video into one bank of a two-bank line buffer while replaying the previous line twice from the other bank at twice the pixel rate.
- Produces a 31 kHz-class stream: dbl_video plus a regenerated dbl_hsync.
- Consumes the video and line_reset signals of the CGA core; feeds the VGA/scaler output path.

Parameters:
- ADDR_W, 10, line-buffer address width; buffer depth per bank = 2**ADDR_W pixels.
- DBL_HSYNC_LEN, 48, width of each dbl_hsync pulse in dbl_ce strobes (1..255).

Ports:
- clk  input  1  system clock (same clock as the CGA core).
- reset  input  1  asynchronous, active-high reset.
- video  input  4  IRGB pixel from the pixel pusher.
- pix_ce  input  1  single-cycle input pixel strobe; video sampled when high.
- line_reset  input  1  single-cycle pulse marking the start of an input line.
- dbl_ce  input  1  single-cycle output pixel strobe; twice the pix_ce rate.
- dbl_video  output  4  doubled-line IRGB pixel.
- dbl_hsync  output  1  active-high doubled horizontal sync.
- line_len  output  ADDR_W+1  pixel count of the line currently being replayed.
- overflow  output  1  sticky flag: an input line exceeded the buffer depth.

Behaviour:
- Reset (async, active-high): all outputs 0, wbank=0, waddr=0, raddr=0, pass=0, sync counter=0, overflow=0. Buffer contents are undefined and not cleared.
- Write side:
  - On pix_ce, write video to buffer[wbank][waddr], then increment waddr.
  - waddr saturates at 2**ADDR_W: further pixels are dropped and overflow is set. overflow clears only on reset.
- line_reset:
  - line_len <= waddr (pixel count of the line just written, 0..2**ADDR_W).
  - wbank toggles; waddr <= 0; raddr <= 0; pass <= 0; sync counter <= DBL_HSYNC_LEN.
  - If pix_ce coincides with line_reset, the pixel is written to address 0 of the new wbank and waddr becomes 1.
- Read side reads from bank ~wbank.
  - On dbl_ce with line_len != 0, the buffer is read at raddr and raddr increments.
  - When raddr reaches line_len-1 and dbl_ce occurs: raddr <= 0.
    - If pass=0: pass <= 1 and sync counter <= DBL_HSYNC_LEN.
    - If pass=1: raddr holds at 0 and reads stop (idle) until the next line_reset.
- Latency: dbl_video is registered and updates on the clk edge one cycle after the dbl_ce that addressed the buffer.
  - In idle, and whenever line_len=0, dbl_video=0.
- dbl_hsync:
  - High while the sync counter is nonzero; the counter decrements on each dbl_ce.
  - Each pass therefore starts with exactly DBL_HSYNC_LEN dbl_ce strobes of sync.
  - dbl_video is forced to 0 while dbl_hsync is high. Pixels are still consumed from the buffer during sync; sync overlays the leading pixels.
  - A reload of the sync counter while it is nonzero restarts the count.
- line_len=0: no reads, no second-pass sync, dbl_video=0. The first-pass sync still fires from line_reset.
- Input line shorter than half the output period: idle fills the remainder. If line_reset arrives mid-pass, the replay is truncated and the new line starts immediately.
- Buffer: 2 × 2**ADDR_W × 4 bits, single write port, single registered read port; inferable as block RAM.

Optional Feature:
- Macro: CGA_LINE_DOUBLER_SCANLINES_EN.
- Defined:
  - Adds input port scanlines (1 bit).
  - When scanlines=1, dbl_video is 4'h0 for every pixel of pass=1, giving dark alternate lines.
  - When scanlines=0, the module behaves exactly as without the macro.
- Not defined: no port is added, and both passes output buffer data.

Test Plan:
- Reset: assert reset mid-line with pix_ce active -> dbl_video=0, dbl_hsync=0, line_len=0, overflow=0 immediately (asynchronous), and they hold while reset is high.
- Basic doubling, 8 pixels:
  - Stimulus: write pixels 1..8 with DBL_HSYNC_LEN=2, pulse line_reset, issue 20 dbl_ce.
  - Required: line_len=8; dbl_hsync high for dbl_ce 1-2, with dbl_video 0,0 during sync. Then 3,4,5,6,7,8 appear, each one clk after its dbl_ce.
  - Second pass: sync again, then 3..8.
  - Then idle with dbl_video=0.
- Coincident strobe: line_reset and pix_ce in the same cycle with video=4'hA -> the new bank's address 0 holds A and the next line's replay starts with A.
- Overflow: with ADDR_W=4, write 20 pixels -> line_len=16 after line_reset, overflow=1 and sticky across the following lines until reset.
- Empty line: two line_reset pulses with no pix_ce between them -> line_len=0, one sync pulse of DBL_HSYNC_LEN, dbl_video=0 throughout, no second sync.
- Scanlines (macro defined, scanlines=1): same stimulus as the basic case -> pass 1 matches the basic case, pass 2 dbl_video=0 for all pixels while dbl_hsync timing is unchanged.
